// File: rtl/song_sequencer.sv
// Two-song, 16-step melody sequencer that drives an external tone generator with a half-period and an enable.
// Define SONG_SEQ_LOOP_EN to let loop=1 restart the latched song from DONE instead of returning to IDLE.
`timescale 1ns/1ps
module song_sequencer #(
    parameter int BEAT_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic        CLOCK_50,
    input  logic        Resetn,
    input  logic        start,
    input  logic        song_sel,
    input  logic        stop,
    input  logic        loop,
    output logic        busy,
    output logic        done,
    output logic        tone_en,
    output logic [19:0] tone_half_period,
    output logic [3:0]  step_idx
);

    localparam int PLAY_CYCLES = BEAT_CYCLES - GAP_CYCLES;
    localparam int CNT_W       = $clog2(BEAT_CYCLES);

    localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(PLAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Note tables, step 0 in the least significant 3 bits.
    localparam logic [47:0] SONG0 = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4,
                                     3'd0, 3'd5, 3'd6, 3'd6, 3'd5, 3'd5, 3'd1, 3'd1};
    localparam logic [47:0] SONG1 = {3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1,
                                     3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};

    function automatic logic [2:0] song_note(input logic sel, input logic [3:0] idx);
        logic [2:0] n;
        if (sel) n = SONG1[int'(idx) * 3 +: 3];
        else     n = SONG0[int'(idx) * 3 +: 3];
        return n;
    endfunction

    function automatic logic [19:0] note_half_period(input logic [2:0] n);
        logic [19:0] hp;
        case (n)
            3'd1:    hp = 20'd191113;
            3'd2:    hp = 20'd170262;
            3'd3:    hp = 20'd151686;
            3'd4:    hp = 20'd143173;
            3'd5:    hp = 20'd127553;
            3'd6:    hp = 20'd113636;
            3'd7:    hp = 20'd101238;
            default: hp = 20'd0;
        endcase
        return hp;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             song_q, song_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tone_en_q, tone_en_d;
    logic [19:0]      half_q, half_d;
    logic [2:0]       note_d;

`ifndef SONG_SEQ_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        song_d  = song_q;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_PLAY;
                    song_d  = song_sel;
                    step_d  = 4'd0;
                    cnt_d   = '0;
                end
            end
            S_PLAY: begin
                if (cnt_q == PLAY_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (step_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_PLAY;
                        step_d  = step_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = 4'd0;
                cnt_d   = '0;
`ifdef SONG_SEQ_LOOP_EN
                if (loop) state_d = S_PLAY;
`endif
            end
            default: begin
                state_d = S_IDLE;
                step_d  = 4'd0;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every transition above, including a loop restart.
        if (stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = 4'd0;
            cnt_d   = '0;
        end

        // Outputs are derived from the next state so they can be registered with no extra cycle of lag.
        note_d    = song_note(song_d, step_d);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        tone_en_d = (state_d == S_PLAY) && (note_d != 3'd0);
        case (state_d)
            S_PLAY:  half_d = note_half_period(note_d);
            S_IDLE:  half_d = 20'd0;
            default: half_d = half_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously on Resetn low.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            step_q    <= 4'd0;
            cnt_q     <= '0;
            song_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tone_en_q <= 1'b0;
            half_q    <= 20'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            song_q    <= song_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tone_en_q <= tone_en_d;
            half_q    <= half_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign tone_en          = tone_en_q;
    assign tone_half_period = half_q;
    assign step_idx         = step_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
`timescale 1ns/1ps
module tb_song_sequencer;

    localparam int BEAT = 10;
    localparam int GAP  = 2;
    localparam int LAST = 16 * BEAT + 2;
`ifdef SONG_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        Resetn   = 1'b0;
    logic        start    = 1'b0;
    logic        song_sel = 1'b0;
    logic        stop     = 1'b0;
    logic        loop     = 1'b0;
    logic        busy, done, tone_en;
    logic [19:0] tone_half_period;
    logic [3:0]  step_idx;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        ten;
        logic [19:0] half;
        logic [3:0]  step;
    } obs_t;

    obs_t sb[$];

    logic [2:0]  s0[16]       = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2, 1, 0};
    logic [2:0]  s1[16]       = '{3, 2, 1, 0, 3, 2, 1, 0, 1, 1, 2, 2, 3, 2, 1, 0};
    logic [19:0] half_tab[8]  = '{0, 191113, 170262, 151686, 143173, 127553, 113636, 101238};

    song_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50         (CLOCK_50),
        .Resetn           (Resetn),
        .start            (start),
        .song_sel         (song_sel),
        .stop             (stop),
        .loop             (loop),
        .busy             (busy),
        .done             (done),
        .tone_en          (tone_en),
        .tone_half_period (tone_half_period),
        .step_idx         (step_idx)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [2:0] note_of(input logic sel, input int k);
        return sel ? s1[k] : s0[k];
    endfunction

    // Expected outputs i cycles after the accepting start edge.
    function automatic obs_t exp_at(input logic sel, input int i, input logic lp);
        obs_t e;
        int k, ph;
        logic [2:0] n;
        e = '0;
        if (i <= 16 * BEAT) begin
            k      = (i - 1) / BEAT;
            ph     = (i - 1) % BEAT;
            n      = note_of(sel, k);
            e.busy = 1'b1;
            e.step = 4'(k);
            e.half = half_tab[n];
            e.ten  = (ph < BEAT - GAP) && (n != 3'd0);
        end else if (i == 16 * BEAT + 1) begin
            e.busy = 1'b1;
            e.done = 1'b1;
            e.step = 4'd15;
            e.half = half_tab[note_of(sel, 15)];
        end else if (lp && LOOP_EN) begin
            n      = note_of(sel, 0);
            e.busy = 1'b1;
            e.half = half_tab[n];
            e.ten  = (n != 3'd0);
        end
        return e;
    endfunction

    function automatic obs_t sample();
        return {busy, done, tone_en, tone_half_period, step_idx};
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        Resetn = 1'b0;
        #3;
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_async got=%h exp=%h", got, obs_t'('0));
        end
        start = 1'b1;
        tick();
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_held got=%h exp=%h", got, obs_t'('0));
        end
        start  = 1'b0;
        Resetn = 1'b1;
    endtask

    task automatic test_song(input logic sel, input logic lp, input string name);
        obs_t got, e;
        int dones;
        dones    = 0;
        song_sel = sel;
        loop     = lp;
        start    = 1'b1;
        for (int i = 1; i <= LAST; i++) sb.push_back(exp_at(sel, i, lp));
        tick();
        start    = 1'b0;
        song_sel = ~sel;
        for (int i = 1; i <= LAST; i++) begin
            if (i > 1) tick();
            got = sample();
            e   = sb.pop_front();
            if (got.done) dones++;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL %s cycle=%0d got=%h exp=%h", name, i, got, e);
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++;
            $display("FAIL %s_done_count got=%0d exp=1", name, dones);
        end
        stop = 1'b1;
        loop = 1'b0;
        tick();
        stop = 1'b0;
        got  = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL %s_final_idle got=%h exp=%h", name, got, obs_t'('0));
        end
    endtask

    task automatic test_stop();
        obs_t got, e;
        song_sel = 1'b0;
        start    = 1'b1;
        for (int i = 1; i <= 52; i++) sb.push_back(exp_at(1'b0, i, 1'b0));
        tick();
        start = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            if (i > 1) tick();
            got = sample();
            e   = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL stop_pre cycle=%0d got=%h exp=%h", i, got, e);
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        got  = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL stop_abort got=%h exp=%h", got, obs_t'('0));
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        got   = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL stop_wins_start got=%h exp=%h", got, obs_t'('0));
        end
        tick();
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL stop_stays_idle got=%h exp=%h", got, obs_t'('0));
        end
    endtask

    task automatic test_ignore_start();
        obs_t got, e;
        song_sel = 1'b0;
        start    = 1'b1;
        for (int i = 1; i <= 62; i++) sb.push_back(exp_at(1'b0, i, 1'b0));
        tick();
        start = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            if (i > 1) begin
                tick();
                start = 1'b0;
            end
            got = sample();
            e   = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL ignore_start cycle=%0d got=%h exp=%h", i, got, e);
            end
            if (i == 45) begin
                start    = 1'b1;
                song_sel = 1'b1;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        song_sel = 1'b1;
        start    = 1'b1;
        for (int i = 1; i <= 9; i++) sb.push_back(exp_at(1'b1, i, 1'b0));
        tick();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (i > 1) tick();
            got = sample();
            e   = sb.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL areset_pre cycle=%0d got=%h exp=%h", i, got, e);
            end
        end
        #2;
        Resetn = 1'b0;
        #1;
        got = sample();
        n_cmp++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL areset_mid_gap got=%h exp=%h", got, obs_t'('0));
        end
        start = 1'b1;
        #2;
        Resetn = 1'b1;
        sb.push_back(exp_at(1'b1, 1, 1'b0));
        tick();
        start = 1'b0;
        got   = sample();
        e     = sb.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL areset_restart got=%h exp=%h", got, e);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_song(1'b0, 1'b0, "song0");
        test_song(1'b1, 1'b0, "song1");
        test_stop();
        test_ignore_start();
        test_async_reset();
        test_song(1'b0, 1'b1, "song0_loop");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
